// File: rtl/wt_dcache_rd_arb.sv
// Round-robin arbiter for the single dcache memory read port. Request fields are
// forwarded in the grant cycle; the winner's tag and response are steered one cycle later.
module wt_dcache_rd_arb #(
   parameter int unsigned DCACHE_TAG_WIDTH    = 20,
   parameter int unsigned DCACHE_OFFSET_WIDTH = 4,
   parameter int unsigned NumPorts            = 3,
   parameter int unsigned DCACHE_CL_IDX_WIDTH = 6,
   parameter int unsigned BlkCntWidth         = 16
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic                                          wr_cl_vld_i,
   input  logic [NumPorts-1:0]                           port_rd_req_i,
   input  logic [NumPorts-1:0]                           port_rd_tag_only_i,
   input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]  port_rd_idx_i,
   input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]  port_rd_off_i,
   input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]     port_rd_tag_i,
   output logic [NumPorts-1:0]                           port_rd_ack_o,
   output logic [NumPorts-1:0]                           port_rsp_vld_o,
   output logic                                          mem_rd_req_o,
   output logic                                          mem_rd_tag_only_o,
   output logic [DCACHE_CL_IDX_WIDTH-1:0]                mem_rd_idx_o,
   output logic [DCACHE_OFFSET_WIDTH-1:0]                mem_rd_off_o,
   output logic [DCACHE_TAG_WIDTH-1:0]                   mem_rd_tag_o,
   input  logic                                          mem_rd_ack_i,
   output logic [BlkCntWidth-1:0]                        blk_cnt_o
);

   localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   typedef logic [PtrW-1:0] ptr_t;

   ptr_t                   rr_ptr_q;
   ptr_t                   owner_q;
   logic                   owner_vld_q;
   logic [BlkCntWidth-1:0] blk_cnt_q;

   ptr_t win;
   logic any_req;
   logic grant;

   // Cyclic scan from the pointer; the candidate index wraps explicitly at NumPorts.
   always_comb begin
      int unsigned cand;
      logic        found;
      win   = rr_ptr_q;
      found = 1'b0;
      for (int unsigned k = 0; k < NumPorts; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NumPorts) cand = cand - NumPorts;
         if (!found && port_rd_req_i[cand]) begin
            win   = ptr_t'(cand);
            found = 1'b1;
         end
      end
   end

   assign any_req      = |port_rd_req_i;
   assign mem_rd_req_o = any_req & ~wr_cl_vld_i;
   assign grant        = mem_rd_req_o & mem_rd_ack_i;

   assign mem_rd_idx_o      = any_req ? port_rd_idx_i[win]      : '0;
   assign mem_rd_off_o      = any_req ? port_rd_off_i[win]      : '0;
   assign mem_rd_tag_only_o = any_req ? port_rd_tag_only_i[win] : 1'b0;

   // The tag is only valid the cycle after the ack, so it follows the registered owner.
   assign mem_rd_tag_o = owner_vld_q ? port_rd_tag_i[owner_q] : '0;
   assign blk_cnt_o    = blk_cnt_q;

   generate
      for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
         assign port_rd_ack_o[gi]  = grant & (win == ptr_t'(gi));
         assign port_rsp_vld_o[gi] = owner_vld_q & (owner_q == ptr_t'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         owner_vld_q <= grant;
         if (grant) begin
            owner_q  <= win;
            rr_ptr_q <= (win == ptr_t'(NumPorts - 1)) ? '0 : win + 1'b1;
         end
         // Saturate rather than wrap so a long block never reads as a short one.
         if (wr_cl_vld_i && any_req && (blk_cnt_q != '1)) begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed bench for wt_dcache_rd_arb: expected grants queue their response and are
// checked one cycle later; a second instance with a 4-bit counter checks saturation.
module tb_wt_dcache_rd_arb;

   localparam int NP   = 3;
   localparam int IDXW = 6;
   localparam int OFFW = 4;
   localparam int TAGW = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                      wr_cl_vld;
   logic [NP-1:0]             req;
   logic [NP-1:0]             tag_only;
   logic [NP-1:0][IDXW-1:0]   idx;
   logic [NP-1:0][OFFW-1:0]   off;
   logic [NP-1:0][TAGW-1:0]   tag;
   logic                      mem_ack;

   logic [NP-1:0]   ack, rsp_vld;
   logic            mem_req, mem_tag_only;
   logic [IDXW-1:0] mem_idx;
   logic [OFFW-1:0] mem_off;
   logic [TAGW-1:0] mem_tag;
   logic [15:0]     blk_cnt;

   logic [NP-1:0]   ack4, rsp_vld4;
   logic            mem_req4, mem_tag_only4;
   logic [IDXW-1:0] mem_idx4;
   logic [OFFW-1:0] mem_off4;
   logic [TAGW-1:0] mem_tag4;
   logic [3:0]      blk_cnt4;

   wt_dcache_rd_arb #(
      .DCACHE_TAG_WIDTH(TAGW), .DCACHE_OFFSET_WIDTH(OFFW), .NumPorts(NP),
      .DCACHE_CL_IDX_WIDTH(IDXW), .BlkCntWidth(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_cl_vld_i(wr_cl_vld),
      .port_rd_req_i(req), .port_rd_tag_only_i(tag_only), .port_rd_idx_i(idx),
      .port_rd_off_i(off), .port_rd_tag_i(tag), .port_rd_ack_o(ack),
      .port_rsp_vld_o(rsp_vld), .mem_rd_req_o(mem_req), .mem_rd_tag_only_o(mem_tag_only),
      .mem_rd_idx_o(mem_idx), .mem_rd_off_o(mem_off), .mem_rd_tag_o(mem_tag),
      .mem_rd_ack_i(mem_ack), .blk_cnt_o(blk_cnt)
   );

   wt_dcache_rd_arb #(
      .DCACHE_TAG_WIDTH(TAGW), .DCACHE_OFFSET_WIDTH(OFFW), .NumPorts(NP),
      .DCACHE_CL_IDX_WIDTH(IDXW), .BlkCntWidth(4)
   ) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .wr_cl_vld_i(wr_cl_vld),
      .port_rd_req_i(req), .port_rd_tag_only_i(tag_only), .port_rd_idx_i(idx),
      .port_rd_off_i(off), .port_rd_tag_i(tag), .port_rd_ack_o(ack4),
      .port_rsp_vld_o(rsp_vld4), .mem_rd_req_o(mem_req4), .mem_rd_tag_only_o(mem_tag_only4),
      .mem_rd_idx_o(mem_idx4), .mem_rd_off_o(mem_off4), .mem_rd_tag_o(mem_tag4),
      .mem_rd_ack_i(mem_ack), .blk_cnt_o(blk_cnt4)
   );

   int n_total = 0;
   int n_pass  = 0;
   int sb[$];

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", nm, obs, exp);
   endtask

   // One cycle: w is the expected winner (-1 = nobody requesting), granted says
   // whether an ack is expected. Response of the previous grant is popped and checked.
   task automatic cyc(input string nm, input int w, input bit granted, input bit exp_req);
      int p;
      logic [31:0] e_ack, e_idx, e_off, e_to;
      @(negedge clk);
      e_ack = '0; e_idx = '0; e_off = '0; e_to = '0;
      if (w >= 0) begin
         e_idx = 32'(idx[w]);
         e_off = 32'(off[w]);
         e_to  = 32'(tag_only[w]);
         if (granted) e_ack = 32'(1) << w;
      end
      chk({nm, " ack"}, 32'(ack), e_ack);
      chk({nm, " mem_req"}, 32'(mem_req), 32'(exp_req));
      chk({nm, " idx"}, 32'(mem_idx), e_idx);
      chk({nm, " off"}, 32'(mem_off), e_off);
      chk({nm, " tag_only"}, 32'(mem_tag_only), e_to);
      if (sb.size() > 0) begin
         p = sb.pop_front();
         chk({nm, " rsp_vld"}, 32'(rsp_vld), 32'(1) << p);
         chk({nm, " mem_tag"}, 32'(mem_tag), 32'(tag[p]));
      end else begin
         chk({nm, " rsp_vld idle"}, 32'(rsp_vld), 32'h0);
         chk({nm, " mem_tag idle"}, 32'(mem_tag), 32'h0);
      end
      if (granted) sb.push_back(w);
      @(posedge clk);
      #1;
   endtask

   initial begin
      wr_cl_vld = 1'b0;
      req       = '0;
      mem_ack   = 1'b1;
      tag_only  = 3'b110;
      idx[0] = 6'h11; idx[1] = 6'h2A; idx[2] = 6'h3C;
      off[0] = 4'h1;  off[1] = 4'h8;  off[2] = 4'hF;
      tag[0] = 20'hAAAAA; tag[1] = 20'h01234; tag[2] = 20'h05678;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset ack", 32'(ack), 32'h0);
      chk("reset mem_req", 32'(mem_req), 32'h0);
      chk("reset rsp_vld", 32'(rsp_vld), 32'h0);
      chk("reset mem_tag", 32'(mem_tag), 32'h0);
      chk("reset mem_idx", 32'(mem_idx), 32'h0);
      chk("reset blk_cnt", 32'(blk_cnt), 32'h0);
      chk("reset blk_cnt4", 32'(blk_cnt4), 32'h0);
      rst_n = 1'b1;

      // All ports request, ack held: 001,010,100,001
      req = 3'b111;
      for (int i = 0; i < 4; i++) cyc($sformatf("t1_c%0d", i), i % 3, 1'b1, 1'b1);
      req = '0;
      cyc("t1_idle", -1, 1'b0, 1'b0);

      // Port1 alone: idx 0x2A / off 0x8 forwarded, tag 0x1234 next cycle
      req = 3'b010;
      cyc("t2_req", 1, 1'b1, 1'b1);
      req = '0;
      cyc("t2_rsp", -1, 1'b0, 1'b0);

      // Ports 0 and 2 blocked for 4 cycles; pointer sits at 2
      chk("t3 blk_cnt before", 32'(blk_cnt), 32'h0);
      req = 3'b101;
      wr_cl_vld = 1'b1;
      for (int i = 0; i < 4; i++) cyc($sformatf("t3_blk%0d", i), 2, 1'b0, 1'b0);
      chk("t3 blk_cnt", 32'(blk_cnt), 32'h4);
      wr_cl_vld = 1'b0;
      cyc("t3_release", 2, 1'b1, 1'b1);
      cyc("t3_next", 0, 1'b1, 1'b1);
      req = '0;
      cyc("t3_idle", -1, 1'b0, 1'b0);
      chk("t3 blk_cnt held", 32'(blk_cnt), 32'h4);

      // Memory withholds ack for 3 cycles with port2 requesting
      mem_ack = 1'b0;
      req = 3'b100;
      for (int i = 0; i < 3; i++) cyc($sformatf("t5_wait%0d", i), 2, 1'b0, 1'b1);
      mem_ack = 1'b1;
      cyc("t5_ack", 2, 1'b1, 1'b1);
      req = '0;
      cyc("t5_idle", -1, 1'b0, 1'b0);

      // Reset right after a grant drops the pending response
      req = 3'b111;
      cyc("t6_grant", 0, 1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6 rsp_vld in reset", 32'(rsp_vld), 32'h0);
      chk("t6 mem_tag in reset", 32'(mem_tag), 32'h0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("t6 blk_cnt after reset", 32'(blk_cnt), 32'h0);
      cyc("t6_after", 0, 1'b1, 1'b1);
      req = '0;
      cyc("t6_idle", -1, 1'b0, 1'b0);

      // Long block: 4-bit counter saturates at 0xF, 16-bit counter reaches 20
      wr_cl_vld = 1'b1;
      req = 3'b001;
      for (int i = 0; i < 20; i++) cyc($sformatf("t4_blk%0d", i), 0, 1'b0, 1'b0);
      chk("t4 blk_cnt4 saturated", 32'(blk_cnt4), 32'hF);
      chk("t4 blk_cnt16", 32'(blk_cnt), 32'd20);
      wr_cl_vld = 1'b0;
      req = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
